bcd_binary_seq: RTL and testbench

- Sequential converter from packed multi-digit BCD to unsigned binary; the inverse of the team's binary-to-BCD converter.
- Processes one digit per clock, most significant digit first, using acc = acc*10 + digit.
- Uses valid/ready handshakes on both input and output, so it drops into streaming datapaths.
- Flags any BCD digit greater than 9 on the result it returns.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_binary_seq_if.sv | 35 +++
 rtl/bcd_digit_mac.sv | 14 +
 rtl/bcd_binary_seq.sv | 111 +++++++++++
 tb/tb_bcd_binary_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit check for the BCD-to-binary converter.
package bcd_pkg;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } conv_state_e;

    function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] d);
        return (d <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_binary_seq_if.sv
// Streaming interface of the BCD-to-binary converter: input word handshake and result handshake.
interface bcd_binary_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);

    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  err
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output err
    );

endinterface

// File: rtl/bcd_digit_mac.sv
// One step of decimal accumulation: acc*10 + digit as shift-add, wrapping in BIN_W bits.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0]       acc_i,
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BIN_W-1:0]       acc_o
);

    assign acc_o = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);

endmodule

// File: rtl/bcd_binary_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Optional build macro BCD_BIN_ERR_CLAMP_EN forces an all-ones result when any digit was > 9.
module bcd_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_binary_seq_if.slave bus
);

    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int WORD_W = DIGITS * BCD_DIGIT_W;

    conv_state_e            state_q, state_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [BIN_W-1:0]       acc_q, acc_d;
    logic [BIN_W-1:0]       bin_q, bin_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   err_out_q, err_out_d;
    logic                   bad_digit;
    logic [BCD_DIGIT_W-1:0] cur_digit;
    logic [BIN_W-1:0]       mac_sum;

    assign cur_digit = word_q[cnt_q*BCD_DIGIT_W +: BCD_DIGIT_W];

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(bus.bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                bad_digit = 1'b1;
            end
        end
    end

    bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
        .acc_i   (acc_q),
        .digit_i (cur_digit),
        .acc_o   (mac_sum)
    );

    // Result registers load only on the final digit so bin_out/err hold outside DONE.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        bin_d     = bin_q;
        err_out_d = err_out_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.bcd_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DIGITS - 1);
                    err_d   = bad_digit;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = mac_sum;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    err_out_d = err_q;
`ifdef BCD_BIN_ERR_CLAMP_EN
                    bin_d     = err_q ? '1 : mac_sum;
`else
                    bin_d     = mac_sum;
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            word_q    <= '0;
            acc_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            acc_q     <= acc_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_out_q <= err_out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.bin_out   = bin_q;
    assign bus.err       = err_out_q;

endmodule

// File: tb/tb_bcd_binary_seq.sv
// Self-checking bench for bcd_binary_seq: scoreboard of model results, directed steps, immediate assertions.
module tb_bcd_binary_seq;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               acceptCycle;
    } exp_t;

    exp_t sbQ[$];
    int   lastOutCycle   = 0;
    int   handshakeCycle = 0;
    int   lastAcceptCycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    bcd_binary_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic modelErr(input logic [15:0] w);
        for (int i = 0; i < DIGITS; i++) begin
            if (w[i*4 +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [BIN_W-1:0] modelBin(input logic [15:0] w);
        int acc;
        acc = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc = acc * 10 + int'(w[i*4 +: 4]);
        end
`ifdef BCD_BIN_ERR_CLAMP_EN
        if (modelErr(w)) return '1;
`endif
        return acc[BIN_W-1:0];
    endfunction

    task automatic checkVal(input string name, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    // Drives a word and waits for the accept edge; returns just after that edge.
    task automatic applyStimulus(input logic [15:0] word, input bit holdValid, input bit push);
        bit ready;
        bit accepted;
        accepted     = 1'b0;
        bus.bcd_in   = word;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 40 && !accepted; n++) begin
            @(negedge clk);
            ready = bus.in_ready;
            @(posedge clk);
            if (ready) accepted = 1'b1;
        end
        #1;
        checkVal("accept_within_bound", 32'(accepted), 32'd1);
        if (!accepted) begin
            bus.in_valid = 1'b0;
            return;
        end
        lastAcceptCycle = cycle;
        if (push) sbQ.push_back('{modelBin(word), modelErr(word), cycle});
        if (!holdValid) bus.in_valid = 1'b0;
    endtask

    // Waits for a result, checks it against the scoreboard, optionally stalls, then handshakes.
    task automatic checkOutput(input int holdCycles, input int expSpacing, input bit fresh);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
            else if (fresh) checkVal("in_ready_busy", 32'(bus.in_ready), 32'd0);
        end
        checkVal("out_valid_within_bound", 32'(seen), 32'd1);
        if (!seen) return;
        checkVal("scoreboard_has_entry", 32'(sbQ.size() > 0), 32'd1);
        if (sbQ.size() == 0) return;
        e = sbQ.pop_front();
        checkVal("bin_out", 32'(bus.bin_out), 32'(e.bin));
        checkVal("err", 32'(bus.err), 32'(e.err));
        checkVal("in_ready_done", 32'(bus.in_ready), 32'd0);
        if (fresh) checkVal("latency", 32'(cycle - e.acceptCycle), 32'(DIGITS));
        if (expSpacing > 0) checkVal("spacing", 32'(cycle - lastOutCycle), 32'(expSpacing));
        lastOutCycle = cycle;
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkVal("hold_out_valid", 32'(bus.out_valid), 32'd1);
            checkVal("hold_bin_out", 32'(bus.bin_out), 32'(e.bin));
            checkVal("hold_err", 32'(bus.err), 32'(e.err));
            checkVal("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        handshakeCycle = cycle;
        checkVal("out_valid_drop", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed time %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.bcd_in    = 16'h9999;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkVal("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("reset_bin_out", 32'(bus.bin_out), 32'd0);
        checkVal("reset_err", 32'(bus.err), 32'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(16'h9999, 1'b0, 1'b1);
        checkOutput(0, 0, 1'b1);
        applyStimulus(16'h0000, 1'b0, 1'b1);
        checkOutput(0, 0, 1'b1);
        applyStimulus(16'h1205, 1'b0, 1'b1);
        checkOutput(0, 0, 1'b1);
        applyStimulus(16'h12A4, 1'b0, 1'b1);
        checkOutput(0, 0, 1'b1);

        // Backpressure with a waiting input word.
        bus.out_ready = 1'b0;
        applyStimulus(16'h0777, 1'b1, 1'b1);
        bus.bcd_in = 16'h0005;
        checkOutput(5, 0, 1'b1);
        applyStimulus(16'h0005, 1'b0, 1'b1);
        checkVal("accept_after_handshake", 32'(lastAcceptCycle - handshakeCycle), 32'd1);
        checkOutput(0, 0, 1'b1);

        // Reset after two digits have been consumed.
        applyStimulus(16'h1234, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkVal("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        checkVal("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        checkVal("midreset_bin_out", 32'(bus.bin_out), 32'd0);
        checkVal("midreset_err", 32'(bus.err), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkVal("midreset_no_output", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(16'h0042, 1'b0, 1'b1);
        checkOutput(0, 0, 1'b1);

        // Back-to-back stream with in_valid held high.
        fork
            begin
                applyStimulus(16'h0001, 1'b1, 1'b1);
                applyStimulus(16'h0010, 1'b1, 1'b1);
                applyStimulus(16'h0100, 1'b0, 1'b1);
            end
            begin
                checkOutput(0, 0, 1'b0);
                checkOutput(0, DIGITS + 2, 1'b0);
                checkOutput(0, DIGITS + 2, 1'b0);
            end
        join
        checkVal("scoreboard_drained", 32'(sbQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
